// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Program loader for the pipeline CPU. Accepts symbolic instructions over a
// valid/ready handshake, encodes each into a 32-bit MIPS word and writes the
// words sequentially into instruction memory. With AUTO_NOP set, a NOP
// delay-slot word follows every branch, J and JR.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   clear               synchronous restart at address 0
//   in_valid/in_ready   handshake for the instruction fields
//   in_mnem             mnemonic code (0..33 legal)
//   in_rs/rt/rd/shamt   register and shift fields
//   in_imm, in_target   immediate / branch offset, jump target
//   imem_we/addr/wdata  instruction memory write port
//   word_count, full    words written since reset/clear, memory full
//   err_illegal         sticky flag: an illegal mnemonic was accepted
module instr_encoder_loader #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned AUTO_NOP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              err_illegal
);

    localparam logic [ADDR_W:0]   DepthC  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W+1:0] DepthW  = (ADDR_W + 2)'(DEPTH);
    localparam logic              NopOn   = (AUTO_NOP != 0);

    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              nop_next_q, nop_next_d;  // current write is a branch; NOP follows
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   alloc_q, alloc_d;        // words reserved by accepted instructions
    logic              err_q, err_d;

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              enc_ds;
    logic              accept;
    logic [1:0]        alloc_inc;
    logic [ADDR_W+1:0] alloc_sum;
    logic              alloc_sat;

    function automatic logic [31:0] r_fmt(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_fmt(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Mnemonic encoder
    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        enc_ds    = 1'b0;
        case (in_mnem)
            6'd0:  enc_word = r_fmt(in_rs, in_rt, in_rd, 5'd0, 6'b100000);
            6'd1:  enc_word = r_fmt(in_rs, in_rt, in_rd, 5'd0, 6'b100001);
            6'd2:  enc_word = r_fmt(in_rs, in_rt, in_rd, 5'd0, 6'b100010);
            6'd3:  enc_word = r_fmt(in_rs, in_rt, in_rd, 5'd0, 6'b100011);
            6'd4:  enc_word = r_fmt(in_rs, in_rt, in_rd, 5'd0, 6'b100100);
            6'd5:  enc_word = r_fmt(in_rs, in_rt, in_rd, 5'd0, 6'b100101);
            6'd6:  enc_word = r_fmt(in_rs, in_rt, in_rd, 5'd0, 6'b100110);
            6'd7:  enc_word = r_fmt(in_rs, in_rt, in_rd, 5'd0, 6'b100111);
            6'd8:  enc_word = r_fmt(in_rs, in_rt, in_rd, 5'd0, 6'b101010);
            6'd9:  enc_word = r_fmt(in_rs, in_rt, in_rd, 5'd0, 6'b101011);
            // Constant shifts carry shamt and have no rs operand
            6'd10: enc_word = r_fmt(5'd0, in_rt, in_rd, in_shamt, 6'b000000);
            6'd11: enc_word = r_fmt(5'd0, in_rt, in_rd, in_shamt, 6'b000010);
            6'd12: enc_word = r_fmt(5'd0, in_rt, in_rd, in_shamt, 6'b000011);
            6'd13: enc_word = r_fmt(in_rs, in_rt, in_rd, 5'd0, 6'b000100);
            6'd14: enc_word = r_fmt(in_rs, in_rt, in_rd, 5'd0, 6'b000110);
            6'd15: enc_word = r_fmt(in_rs, in_rt, in_rd, 5'd0, 6'b000111);
            6'd16: begin
                enc_word = r_fmt(in_rs, 5'd0, 5'd0, 5'd0, 6'b001000);
                enc_ds   = 1'b1;
            end
            6'd17: enc_word = i_fmt(6'b001000, in_rs, in_rt, in_imm);
            6'd18: enc_word = i_fmt(6'b001001, in_rs, in_rt, in_imm);
            6'd19: enc_word = i_fmt(6'b001100, in_rs, in_rt, in_imm);
            6'd20: enc_word = i_fmt(6'b001101, in_rs, in_rt, in_imm);
            6'd21: enc_word = i_fmt(6'b001110, in_rs, in_rt, in_imm);
            6'd22: enc_word = i_fmt(6'b001010, in_rs, in_rt, in_imm);
            6'd23: enc_word = i_fmt(6'b001011, in_rs, in_rt, in_imm);
            6'd24: enc_word = i_fmt(6'b100011, in_rs, in_rt, in_imm);
            6'd25: enc_word = i_fmt(6'b101011, in_rs, in_rt, in_imm);
            6'd26: begin
                enc_word = i_fmt(6'b000100, in_rs, in_rt, in_imm);
                enc_ds   = 1'b1;
            end
            6'd27: begin
                enc_word = i_fmt(6'b000101, in_rs, in_rt, in_imm);
                enc_ds   = 1'b1;
            end
            // Branch-on-rs: the rt field selects the condition, in_rt is ignored
            6'd28: begin
                enc_word = i_fmt(6'b000001, in_rs, 5'd1, in_imm);
                enc_ds   = 1'b1;
            end
            6'd29: begin
                enc_word = i_fmt(6'b000111, in_rs, 5'd0, in_imm);
                enc_ds   = 1'b1;
            end
            6'd30: begin
                enc_word = i_fmt(6'b000110, in_rs, 5'd0, in_imm);
                enc_ds   = 1'b1;
            end
            6'd31: begin
                enc_word = i_fmt(6'b000001, in_rs, 5'd0, in_imm);
                enc_ds   = 1'b1;
            end
            6'd32: begin
                enc_word = {6'b000010, in_target};
                enc_ds   = 1'b1;
            end
            6'd33:   enc_word = 32'h0;
            default: enc_legal = 1'b0;
        endcase
    end

    assign in_ready = rst_n && !clear && (alloc_q < DepthC) && !nop_next_q;
    assign accept   = in_valid && in_ready;

    // Space reservation: a delay-slot mnemonic needs two words when NOPs are enabled
    always_comb begin
        if (!enc_legal) begin
            alloc_inc = 2'd0;
        end else if (enc_ds && NopOn) begin
            alloc_inc = 2'd2;
        end else begin
            alloc_inc = 2'd1;
        end
    end

    assign alloc_sum = {1'b0, alloc_q} + (ADDR_W + 2)'(alloc_inc);
    assign alloc_sat = (alloc_sum > DepthW);

    always_comb begin
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        nop_next_d = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        alloc_d    = alloc_q;
        err_d      = err_q;
        if (clear) begin
            wdata_d  = 32'h0;
            wr_ptr_d = '0;
            count_d  = '0;
            alloc_d  = '0;
            err_d    = 1'b0;
        end else begin
            if (we_q) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                count_d  = count_q + (ADDR_W + 1)'(1);
            end
            if (nop_next_q) begin
                we_d    = 1'b1;
                wdata_d = 32'h0;
            end else if (accept) begin
                if (!enc_legal) begin
                    err_d = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    wdata_d = enc_word;
                    // Drop the NOP when only one word is left for the branch
                    nop_next_d = NopOn && enc_ds && !alloc_sat;
                end
                alloc_d = alloc_sat ? DepthC : alloc_sum[ADDR_W:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            wdata_q    <= 32'h0;
            nop_next_q <= 1'b0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            alloc_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            nop_next_q <= nop_next_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            alloc_q    <= alloc_d;
            err_q      <= err_d;
        end
    end

    // A write in flight is suppressed if reset or clear arrives in its cycle
    assign imem_we     = we_q && rst_n && !clear;
    assign imem_addr   = wr_ptr_q;
    assign imem_wdata  = wdata_q;
    assign word_count  = count_q;
    assign full        = (count_q == DepthC);
    assign err_illegal = err_q;

endmodule
